uart_tx_frame_arbiter: RTL and testbench
========================================

Name: uart_tx_frame_arbiter

Overview:
- Shares one uart_transmitter between NUM_REQ requesters (e.g. flag logic, debug dump).
- Each requester submits a whole frame of FRAME_SIZE bytes. The block grants round-robin, snapshots the frame, and feeds bytes to the transmitter one at a time with a tx_start/tx_done handshake.
- Sits between the requester logic and the transmitter instance in top-level designs.

Parameters:
- DBITS, 8, bits per UART data word.
- FRAME_SIZE, 4, bytes per frame.
- NUM_REQ, 2, number of requesters (2..8).
- DONE_TIMEOUT, 2000000, clk cycles to wait for tx_done before aborting a frame (0 disables the timeout).

Ports:
- clk_100MHz  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester frame request (level).
- req_frame  in  NUM_REQ*FRAME_SIZE*DBITS  frames, flattened; requester i occupies slice i, byte 0 in the LSBs.
- grant  out  NUM_REQ  one-hot, 1-cycle pulse when requester i's frame is captured.
- frame_done  out  NUM_REQ  one-hot, 1-cycle pulse when requester i's frame completes or aborts.
- frame_err  out  1  1-cycle pulse, coincident with frame_done, when a frame was aborted by timeout.
- tx_start  out  1  1-cycle start pulse to the transmitter.
- tx_data  out  DBITS  byte to the transmitter, stable from tx_start until tx_done.
- tx_done  in  1  1-cycle completion pulse from the transmitter.
- busy  out  1  high in every state except IDLE.
- owner  out  3  index of the current or last owner.

Behaviour:
- Reset (asynchronous, reset_n=0) drives these values immediately:
  - grant, frame_done, frame_err, tx_start, busy all 0.
  - tx_data 0, owner 0.
  - Round-robin pointer rr 0; state IDLE.
- FSM states: IDLE, LOAD, START, WAIT, NEXT.
- IDLE:
  - If any req bit is high, pick the first set bit searching from rr upward, with wrap-around.
  - Go to LOAD and set owner.
- LOAD (1 cycle):
  - Copy the owner's frame slice into an internal buffer.
  - Pulse grant[owner]; clear byte index idx to 0.
  - Go to START.
  - req_frame is sampled only in this cycle. Later changes to the requester's input do not affect the frame in flight.
- START (1 cycle):
  - tx_data = buffer byte idx; tx_start = 1.
  - Load the timeout counter; go to WAIT.
- WAIT:
  - tx_data is held.
  - On tx_done: go to NEXT.
  - Else if DONE_TIMEOUT≠0 and the counter reaches 0: pulse frame_done[owner] and frame_err, then set rr = owner+1 mod NUM_REQ and go to IDLE.
- NEXT (1 cycle):
  - If idx == FRAME_SIZE-1: pulse frame_done[owner], set rr = owner+1 mod NUM_REQ, go to IDLE.
  - Else: idx += 1 and go to START.
- Timing:
  - Latency from req asserted in IDLE to the first tx_start: 2 cycles (LOAD, then START).
  - Gap from tx_done to the next tx_start: 2 cycles (NEXT, then START).
- Boundary conditions:
  - tx_done outside WAIT is ignored.
  - A req dropped after grant does not cancel the frame.
  - A req still high after frame_done is rearbitrated: it is served again only after the other pending requesters (fairness).
  - All req low: stay in IDLE; rr unchanged.
  - Reset mid-frame abandons the frame with no frame_done pulse. The transmitter is reset by the same reset.
  - idx width is clog2(FRAME_SIZE), minimum 1 bit. owner is zero-extended to 3 bits.

Decomposition:
- Shared package uart_pkg: DBITS, FRAME_SIZE, FSM state encoding, clog2 helper.
- Sub-module rr_arbiter (parameter N): inputs req and rr pointer; combinational outputs valid and index.

Test Plan:
1. Single frame: req=01, frame0 = 0x44_33_22_11, tx_done pulsed 10 cycles after each tx_start.
   - Response: grant=01 one cycle after req.
   - tx_data sequence 0x11, 0x22, 0x33, 0x44, one tx_start each.
   - Then frame_done=01 with frame_err=0; busy falls the cycle after.
2. Contention: req=11 held, starting from reset.
   - Response: frames are served in order 0, 1, 0, 1; grant pulses 01, 10, 01, 10.
3. Frame snapshot: change frame0 to 0xFFFFFFFF one cycle after grant.
   - Response: transmitted bytes are still the originally latched values.
4. Timeout: DONE_TIMEOUT=50, tx_done never pulsed.
   - Response: 50 cycles after the first tx_start, frame_done=01 and frame_err=1.
   - FSM returns to IDLE; next requester is 1.
5. Reset during WAIT of byte 2:
   - Response: all outputs go to 0 asynchronously and no frame_done pulses.
   - After release with req=10, requester 1 is served first (rr was reset to 0, and no other request is pending).
6. Spurious tx_done while IDLE, and during START:
   - Response: no state change; the byte sequence is unaffected.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit frame arbiter.
// Contents: default data/frame sizes, FSM state encoding, and width helpers.
package uart_pkg;

    localparam int UART_DBITS      = 8;
    localparam int UART_FRAME_SIZE = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_NEXT  = 3'd4
    } state_t;

    // Ceiling log2; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 32'sd0;
        remaining = value - 32'sd1;
        while (remaining > 32'sd0) begin
            result    = result + 32'sd1;
            remaining = remaining >>> 1;
        end
        return result;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int width_of(input int value);
        return (clog2(value) < 32'sd1) ? 32'sd1 : clog2(value);
    endfunction

endpackage

// File: rtl/uart_tx_frame_arbiter_if.sv
// Byte handshake between the frame arbiter and the UART transmitter.
// Signals: tx_start (1-cycle start pulse), tx_data (byte, held until tx_done),
//          tx_done (1-cycle completion pulse from the transmitter).
// master = arbiter side, slave = transmitter side.
interface uart_tx_frame_arbiter_if
    import uart_pkg::*;
#(
    parameter int DW = UART_DBITS
);
    logic          tx_start;
    logic [DW-1:0] tx_data;
    logic          tx_done;

    modport master (output tx_start, output tx_data, input tx_done);
    modport slave  (input tx_start, input tx_data, output tx_done);
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Ports: i_req (request vector), i_rr (search start index),
//        o_valid (any request set), o_index (first set bit at or after i_rr, wrapping).
module rr_arbiter
    import uart_pkg::*;
#(
    parameter  int N  = 2,
    localparam int IW = width_of(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_rr,
    output logic          o_valid,
    output logic [IW-1:0] o_index
);

    // Scan from the farthest candidate back to i_rr so the nearest set bit wins.
    always_comb begin : pick
        int cand;
        o_valid = 1'b0;
        o_index = '0;
        cand    = 32'sd0;
        for (int k = N - 1; k >= 0; k--) begin
            cand    = int'(i_rr) + k;
            cand    = (cand >= N) ? (cand - N) : cand;
            o_valid = i_req[cand] ? 1'b1 : o_valid;
            o_index = i_req[cand] ? IW'(cand) : o_index;
        end
    end

endmodule

// File: rtl/uart_tx_frame_arbiter.sv
// Shares one UART transmitter between NUM_REQ frame requesters.
// A granted frame is snapshotted and sent byte by byte over the tx handshake.
// Ports: clk_100MHz, reset_n (async, active low); req / req_frame (requests and
//        flattened frames, requester i in slice i, byte 0 in LSBs); grant,
//        frame_done, frame_err (1-cycle pulses); busy; owner (current/last owner);
//        tx (master side of the transmitter handshake).
module uart_tx_frame_arbiter
    import uart_pkg::*;
#(
    parameter int DBITS        = UART_DBITS,
    parameter int FRAME_SIZE   = UART_FRAME_SIZE,
    parameter int NUM_REQ      = 2,
    parameter int DONE_TIMEOUT = 2000000
) (
    input  logic                                clk_100MHz,
    input  logic                                reset_n,
    input  logic [NUM_REQ-1:0]                  req,
    input  logic [NUM_REQ*FRAME_SIZE*DBITS-1:0] req_frame,
    output logic [NUM_REQ-1:0]                  grant,
    output logic [NUM_REQ-1:0]                  frame_done,
    output logic                                frame_err,
    output logic                                busy,
    output logic [2:0]                          owner,
    uart_tx_frame_arbiter_if.master             tx
);

    localparam int FW = FRAME_SIZE * DBITS;
    localparam int IW = width_of(NUM_REQ);
    localparam int XW = width_of(FRAME_SIZE);
    localparam int TW = width_of(DONE_TIMEOUT + 1);
    localparam bit TMO_EN = (DONE_TIMEOUT != 0);
    // Loaded one short: the abort is registered, so frame_done lands DONE_TIMEOUT cycles after tx_start.
    localparam logic [TW-1:0]      TMO_LOAD     = TW'((DONE_TIMEOUT > 0) ? (DONE_TIMEOUT - 1) : 0);
    localparam logic [XW-1:0]      LAST_IDX     = XW'(FRAME_SIZE - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT_BASE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    state_t             r_state, w_state_next;
    logic [IW-1:0]      r_owner, w_owner_next;
    logic [IW-1:0]      r_rr, w_rr_next, w_rr_after;
    logic [XW-1:0]      r_idx, w_idx_next;
    logic [FW-1:0]      r_buf, w_buf_next;
    logic [TW-1:0]      r_tmo, w_tmo_next;
    logic [NUM_REQ-1:0] r_grant, w_grant_next;
    logic [NUM_REQ-1:0] r_frame_done, w_done_next;
    logic               r_frame_err, w_err_next;
    logic               r_tx_start, w_start_next;
    logic [DBITS-1:0]   r_tx_data, w_tx_data_next;
    logic               r_busy, w_busy_next;
    logic               w_arb_valid;
    logic [IW-1:0]      w_arb_index;
    logic [NUM_REQ-1:0] w_owner_onehot;

    rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
        .i_req   (req),
        .i_rr    (r_rr),
        .o_valid (w_arb_valid),
        .o_index (w_arb_index)
    );

    assign w_owner_onehot = ONE_HOT_BASE << r_owner;
    assign w_rr_after     = (int'(r_owner) == (NUM_REQ - 1)) ? '0 : (r_owner + IW'(1));

    // Next-state and next-output decode; pulses are decoded one cycle early so they register into the named state.
    always_comb begin
        w_state_next = r_state;
        w_owner_next = r_owner;
        w_rr_next    = r_rr;
        w_idx_next   = r_idx;
        w_buf_next   = r_buf;
        w_tmo_next   = r_tmo;
        w_grant_next = '0;
        w_done_next  = '0;
        w_err_next   = 1'b0;
        w_start_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_valid) begin
                    w_owner_next = w_arb_index;
                    w_grant_next = ONE_HOT_BASE << w_arb_index;
                    w_state_next = ST_LOAD;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // The only cycle req_frame is looked at.
                w_buf_next   = req_frame[int'(r_owner) * FW +: FW];
                w_idx_next   = '0;
                w_start_next = 1'b1;
                w_state_next = ST_START;
            end
            ST_START: begin
                w_tmo_next   = TMO_LOAD;
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx.tx_done) begin
                    w_done_next  = (r_idx == LAST_IDX) ? w_owner_onehot : '0;
                    w_state_next = ST_NEXT;
                end else if (TMO_EN && (r_tmo <= TW'(1))) begin
                    w_done_next  = w_owner_onehot;
                    w_err_next   = 1'b1;
                    w_rr_next    = w_rr_after;
                    w_state_next = ST_IDLE;
                end else begin
                    w_tmo_next = r_tmo - TW'(1);
                end
            end
            ST_NEXT: begin
                if (r_idx == LAST_IDX) begin
                    w_rr_next    = w_rr_after;
                    w_state_next = ST_IDLE;
                end else begin
                    w_idx_next   = r_idx + XW'(1);
                    w_start_next = 1'b1;
                    w_state_next = ST_START;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_tx_data_next = w_start_next ? w_buf_next[int'(w_idx_next) * DBITS +: DBITS] : r_tx_data;
    assign w_busy_next    = (w_state_next != ST_IDLE);

    // State, datapath and registered outputs.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_owner      <= '0;
            r_rr         <= '0;
            r_idx        <= '0;
            r_buf        <= '0;
            r_tmo        <= '0;
            r_grant      <= '0;
            r_frame_done <= '0;
            r_frame_err  <= 1'b0;
            r_tx_start   <= 1'b0;
            r_tx_data    <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_owner      <= w_owner_next;
            r_rr         <= w_rr_next;
            r_idx        <= w_idx_next;
            r_buf        <= w_buf_next;
            r_tmo        <= w_tmo_next;
            r_grant      <= w_grant_next;
            r_frame_done <= w_done_next;
            r_frame_err  <= w_err_next;
            r_tx_start   <= w_start_next;
            r_tx_data    <= w_tx_data_next;
            r_busy       <= w_busy_next;
        end
    end

    assign grant       = r_grant;
    assign frame_done  = r_frame_done;
    assign frame_err   = r_frame_err;
    assign busy        = r_busy;
    assign owner       = 3'(r_owner);
    assign tx.tx_start = r_tx_start;
    assign tx.tx_data  = r_tx_data;

endmodule

// File: tb/tb_uart_tx_frame_arbiter.sv
// Directed bench for uart_tx_frame_arbiter (2 requesters, 4-byte frames, timeout 50).
module tb_uart_tx_frame_arbiter;

    logic        clk;
    logic        reset_n;
    logic [1:0]  req;
    logic [63:0] req_frame;
    logic [1:0]  grant;
    logic [1:0]  frame_done;
    logic        frame_err;
    logic        busy;
    logic [2:0]  owner;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    uart_tx_frame_arbiter_if #(.DW(8)) tx_if ();

    uart_tx_frame_arbiter #(
        .DBITS(8), .FRAME_SIZE(4), .NUM_REQ(2), .DONE_TIMEOUT(50)
    ) dut (
        .clk_100MHz (clk),
        .reset_n    (reset_n),
        .req        (req),
        .req_frame  (req_frame),
        .grant      (grant),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .busy       (busy),
        .owner      (owner),
        .tx         (tx_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(input logic [1:0] g, input string tag);
        int k = 0;
        while (grant === 2'b00 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_grant"}, {30'd0, grant}, {30'd0, g});
    endtask

    task automatic wait_start(input string tag, output int waited);
        waited = 0;
        while (tx_if.tx_start !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_start"}, {31'd0, tx_if.tx_start}, 32'd1);
    endtask

    task automatic pulse_done(input logic [7:0] exp, input string tag);
        tx_if.tx_done = 1'b1;
        check({tag, "_hold"}, {24'd0, tx_if.tx_data}, {24'd0, exp});
        @(negedge clk);
        tx_if.tx_done = 1'b0;
    endtask

    // Called on the tx_start cycle; answers tx_done 10 cycles later.
    task automatic finish_byte(input logic [7:0] exp, input string tag);
        @(negedge clk);
        check({tag, "_pulse"}, {31'd0, tx_if.tx_start}, 32'd0);
        repeat (9) @(negedge clk);
        pulse_done(exp, tag);
    endtask

    task automatic serve_byte(input logic [7:0] exp, input string tag, output int waited);
        wait_start(tag, waited);
        check({tag, "_data"}, {24'd0, tx_if.tx_data}, {24'd0, exp});
        finish_byte(exp, tag);
    endtask

    // Called on the cycle after the last tx_done.
    task automatic frame_end(input logic [1:0] g, input bit clear, input string tag);
        check({tag, "_done"}, {30'd0, frame_done}, {30'd0, g});
        check({tag, "_err"}, {31'd0, frame_err}, 32'd0);
        check({tag, "_busy_hi"}, {31'd0, busy}, 32'd1);
        if (clear) req = 2'b00;
        @(negedge clk);
        check({tag, "_busy_lo"}, {31'd0, busy}, 32'd0);
        check({tag, "_done_pulse"}, {30'd0, frame_done}, 32'd0);
    endtask

    task automatic serve_frame(input logic [1:0] g, input logic [31:0] frame,
                               input bit drop, input bit clear, input string tag);
        int w;
        wait_grant(g, tag);
        if (drop) req = req & ~g;
        for (int i = 0; i < 4; i++) begin
            serve_byte(frame[i*8 +: 8], $sformatf("%s_b%0d", tag, i), w);
        end
        frame_end(g, clear, tag);
    endtask

    initial begin
        int  w;
        logic seen;
        tx_if.tx_done = 1'b0;
        req           = 2'b00;
        req_frame     = 64'd0;
        reset_n       = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_grant", {30'd0, grant}, 32'd0);
        check("rst_done", {30'd0, frame_done}, 32'd0);
        check("rst_err", {31'd0, frame_err}, 32'd0);
        check("rst_start", {31'd0, tx_if.tx_start}, 32'd0);
        check("rst_data", {24'd0, tx_if.tx_data}, 32'd0);
        check("rst_owner", {29'd0, owner}, 32'd0);
        reset_n   = 1'b1;
        req_frame = {32'h88776655, 32'h44332211};
        @(negedge clk);

        // 1: single frame with exact latencies
        req = 2'b01;
        @(negedge clk);
        check("t1_grant", {30'd0, grant}, 32'd1);
        check("t1_busy", {31'd0, busy}, 32'd1);
        req = 2'b00;
        @(negedge clk);
        check("t1_b0_start", {31'd0, tx_if.tx_start}, 32'd1);
        check("t1_b0_data", {24'd0, tx_if.tx_data}, 32'h11);
        finish_byte(8'h11, "t1_b0");
        serve_byte(8'h22, "t1_b1", w);
        check("t1_gap", w, 32'd1);
        serve_byte(8'h33, "t1_b2", w);
        serve_byte(8'h44, "t1_b3", w);
        frame_end(2'b01, 1'b0, "t1");

        // 6: spurious tx_done in IDLE and in START
        repeat (2) @(negedge clk);
        tx_if.tx_done = 1'b1;
        @(negedge clk);
        tx_if.tx_done = 1'b0;
        check("t6_idle_busy", {31'd0, busy}, 32'd0);
        check("t6_idle_start", {31'd0, tx_if.tx_start}, 32'd0);
        req_frame[31:0] = 32'hA4A3A2A1;
        req = 2'b01;
        wait_grant(2'b01, "t6");
        req = 2'b00;
        wait_start("t6_b0", w);
        check("t6_b0_data", {24'd0, tx_if.tx_data}, 32'hA1);
        tx_if.tx_done = 1'b1;
        @(negedge clk);
        tx_if.tx_done = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | tx_if.tx_start;
        end
        check("t6_no_advance", {31'd0, seen}, 32'd0);
        pulse_done(8'hA1, "t6_b0");
        serve_byte(8'hA2, "t6_b1", w);
        serve_byte(8'hA3, "t6_b2", w);
        serve_byte(8'hA4, "t6_b3", w);
        frame_end(2'b01, 1'b0, "t6");

        // 3: frame snapshot
        req_frame[31:0] = 32'hDDCCBBAA;
        req = 2'b01;
        wait_grant(2'b01, "t3");
        req = 2'b00;
        @(negedge clk);
        req_frame[31:0] = 32'hFFFFFFFF;
        serve_byte(8'hAA, "t3_b0", w);
        serve_byte(8'hBB, "t3_b1", w);
        serve_byte(8'hCC, "t3_b2", w);
        serve_byte(8'hDD, "t3_b3", w);
        frame_end(2'b01, 1'b0, "t3");
        req_frame[31:0] = 32'h44332211;

        // 4: timeout, then requester 1 is next
        req = 2'b01;
        wait_grant(2'b01, "t4");
        req = 2'b10;
        wait_start("t4_b0", w);
        check("t4_b0_data", {24'd0, tx_if.tx_data}, 32'h11);
        repeat (49) @(negedge clk);
        check("t4_early", {30'd0, frame_done}, 32'd0);
        @(negedge clk);
        check("t4_done", {30'd0, frame_done}, 32'd1);
        check("t4_err", {31'd0, frame_err}, 32'd1);
        serve_frame(2'b10, 32'h88776655, 1'b1, 1'b0, "t4_r1");

        // 5: reset during WAIT of byte 2
        req = 2'b10;
        wait_grant(2'b10, "t5a");
        req = 2'b00;
        serve_byte(8'h55, "t5a_b0", w);
        wait_start("t5a_b1", w);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        check("t5_rst_start", {31'd0, tx_if.tx_start}, 32'd0);
        check("t5_rst_data", {24'd0, tx_if.tx_data}, 32'd0);
        check("t5_rst_owner", {29'd0, owner}, 32'd0);
        check("t5_rst_done", {30'd0, frame_done}, 32'd0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | (|frame_done);
        end
        reset_n = 1'b1;
        req = 2'b10;
        @(negedge clk);
        seen = seen | (|frame_done);
        check("t5_no_done", {31'd0, seen}, 32'd0);
        check("t5_grant", {30'd0, grant}, 32'd2);
        req = 2'b00;
        serve_byte(8'h55, "t5_b0", w);
        serve_byte(8'h66, "t5_b1", w);
        serve_byte(8'h77, "t5_b2", w);
        serve_byte(8'h88, "t5_b3", w);
        frame_end(2'b10, 1'b0, "t5");

        // 2: contention from reset
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        req = 2'b11;
        serve_frame(2'b01, 32'h44332211, 1'b0, 1'b0, "t2_f0");
        serve_frame(2'b10, 32'h88776655, 1'b0, 1'b0, "t2_f1");
        serve_frame(2'b01, 32'h44332211, 1'b0, 1'b0, "t2_f2");
        serve_frame(2'b10, 32'h88776655, 1'b0, 1'b1, "t2_f3");
        repeat (5) @(negedge clk);
        check("t2_idle_busy", {31'd0, busy}, 32'd0);
        check("t2_idle_grant", {30'd0, grant}, 32'd0);
        check("t2_owner", {29'd0, owner}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
